// File: rtl/next_pc_unit.sv
// next_pc_unit: architectural PC register with a boot/run/halt FSM.
// Computes the next fetch PC from the decoded branch op each update cycle.
module next_pc_unit #(
  parameter int W = 64,
  parameter logic [W-1:0] RESET_PC = '0,
  parameter int INC = 1,
  parameter int OFFSET_SHIFT = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       branch_op,
  input  logic [W-1:0]     se_offset,
  input  logic [W-1:0]     reg_target,
  input  logic             zero_flag,
  input  logic             instr_valid,
  input  logic             fetch_ready,
  output logic [W-1:0]     pc,
  output logic [W-1:0]     pc_plus,
  output logic             pc_valid,
  output logic             taken,
  output logic             halted,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  localparam logic [W-1:0] INC_W = W'(INC);

  state_t           state, state_d;
  logic [W-1:0]     pc_d;
  logic             taken_d;
  logic [CNT_W-1:0] cnt_d;

  logic         upd;
  logic         is_b, is_cbz, is_cbnz, is_br, is_halt;
  logic         rel_take, any_take, cnt_sat;
  logic [W-1:0] offset_sh;

  assign pc_valid  = (state == S_RUN);
  assign halted    = (state == S_HALT);
  assign pc_plus   = pc + INC_W;
  assign upd       = pc_valid & fetch_ready & instr_valid;
  assign offset_sh = se_offset << OFFSET_SHIFT;

  assign is_b     = (branch_op == 3'b001);
  assign is_cbz   = (branch_op == 3'b010);
  assign is_cbnz  = (branch_op == 3'b011);
  assign is_br    = (branch_op == 3'b100);
  assign is_halt  = (branch_op == 3'b101);
  assign rel_take = is_b | (is_cbz & zero_flag) | (is_cbnz & ~zero_flag);
  assign any_take = rel_take | is_br;
  assign cnt_sat  = &taken_count;

  // Next-state, next-pc and redirect bookkeeping
  always_comb begin
    state_d = state;
    pc_d    = pc;
    taken_d = 1'b0;
    cnt_d   = taken_count;
    unique case (state)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (upd) begin
          unique case (1'b1)
            is_halt:  state_d = S_HALT;
            is_br:    pc_d = reg_target;
            rel_take: pc_d = pc + offset_sh;
            default:  pc_d = pc_plus;
          endcase
          taken_d = any_take;
          if (any_take && !cnt_sat)
            cnt_d = taken_count + CNT_W'(1);
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  // State and PC registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      taken       <= 1'b0;
      taken_count <= '0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      taken       <= taken_d;
      taken_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: directed plan steps plus randomized traffic,
// all checked against a behavioural PC model.
module tb_next_pc_unit;

  localparam int W = 64;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       branch_op;
  logic [W-1:0]     se_offset;
  logic [W-1:0]     reg_target;
  logic             zero_flag;
  logic             instr_valid;
  logic             fetch_ready;
  logic [W-1:0]     pc;
  logic [W-1:0]     pc_plus;
  logic             pc_valid;
  logic             taken;
  logic             halted;
  logic [CNT_W-1:0] taken_count;

  int tests = 0;
  int fails = 0;

  // model state
  logic [W-1:0] m_pc;
  bit           m_boot, m_run, m_halt, m_taken;
  int           m_cnt;

  next_pc_unit #(
    .W(W), .RESET_PC('0), .INC(1), .OFFSET_SHIFT(0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .branch_op(branch_op),
    .se_offset(se_offset), .reg_target(reg_target),
    .zero_flag(zero_flag), .instr_valid(instr_valid),
    .fetch_ready(fetch_ready), .pc(pc), .pc_plus(pc_plus),
    .pc_valid(pc_valid), .taken(taken), .halted(halted),
    .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply the architectural rules for one rising edge
  task automatic model_edge();
    bit tk;
    logic [W-1:0] tgt;
    tk  = 0;
    tgt = m_pc + se_offset;
    if (!rst_n) begin
      m_pc = '0; m_boot = 1; m_run = 0; m_halt = 0;
      m_taken = 0; m_cnt = 0;
    end else if (m_boot) begin
      m_boot = 0; m_run = 1; m_taken = 0;
    end else if (m_run) begin
      m_taken = 0;
      if (fetch_ready && instr_valid) begin
        case (branch_op)
          3'd1: begin m_pc = tgt; tk = 1; end
          3'd2: if (zero_flag) begin m_pc = tgt; tk = 1; end
                else m_pc = m_pc + 1;
          3'd3: if (!zero_flag) begin m_pc = tgt; tk = 1; end
                else m_pc = m_pc + 1;
          3'd4: begin m_pc = reg_target; tk = 1; end
          3'd5: begin m_run = 0; m_halt = 1; end
          default: m_pc = m_pc + 1;
        endcase
        m_taken = tk;
        if (tk && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc_plus"}, pc_plus, m_pc + 64'd1);
    chk({tag, ".pc_valid"}, W'(pc_valid), W'(m_run));
    chk({tag, ".taken"}, W'(taken), W'(m_taken));
    chk({tag, ".halted"}, W'(halted), W'(m_halt));
    chk({tag, ".count"}, W'(taken_count), W'(m_cnt));
  endtask

  task automatic step(string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_model(tag);
  endtask

  task automatic drive(logic [2:0] op, logic [W-1:0] off,
                       logic [W-1:0] tgt, logic z);
    branch_op = op; se_offset = off; reg_target = tgt; zero_flag = z;
  endtask

  initial begin
    rst_n = 0; fetch_ready = 1; instr_valid = 1;
    drive(3'd0, '0, '0, 0);
    m_pc = '0; m_boot = 1; m_run = 0; m_halt = 0; m_taken = 0; m_cnt = 0;

    // reset and boot
    repeat (3) step("reset");
    chk("reset_pc", pc, 64'd0);
    chk("reset_valid", W'(pc_valid), 64'd0);
    rst_n = 1;
    #1 chk("boot_valid_low", W'(pc_valid), 64'd0);
    step("boot");
    chk("boot_valid_high", W'(pc_valid), 64'd1);
    chk("boot_pc", pc, 64'd0);

    // sequential then stall
    repeat (4) step("seq");
    chk("seq_pc4", pc, 64'd4);
    fetch_ready = 0;
    drive(3'd1, 64'd100, '0, 0);
    repeat (2) step("stall");
    chk("stall_pc", pc, 64'd4);
    chk("stall_taken", W'(taken), 64'd0);
    fetch_ready = 1;

    // branches
    drive(3'd1, 64'hFFFF_FFFF_FFFF_FFFD, '0, 0);
    step("b_neg");
    chk("b_neg_pc", pc, 64'd1);
    chk("b_neg_taken", W'(taken), 64'd1);
    chk("b_neg_cnt", W'(taken_count), 64'd1);
    drive(3'd2, 64'd10, '0, 0);
    step("cbz_nt");
    chk("cbz_nt_pc", pc, 64'd2);
    chk("cbz_nt_taken", W'(taken), 64'd0);
    drive(3'd3, 64'd10, '0, 0);
    step("cbnz_t");
    chk("cbnz_t_pc", pc, 64'd12);
    chk("cbnz_t_cnt", W'(taken_count), 64'd2);

    // BR and wrap
    drive(3'd4, '0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    step("br");
    chk("br_pc", pc, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("br_pc_plus", pc_plus, 64'd0);
    drive(3'd0, '0, '0, 0);
    step("wrap");
    chk("wrap_pc", pc, 64'd0);

    // halt at 7
    drive(3'd4, '0, 64'd7, 0);
    step("br7");
    drive(3'd5, '0, '0, 0);
    fetch_ready = 0;
    step("halt_stalled");
    chk("halt_stalled_h", W'(halted), 64'd0);
    fetch_ready = 1;
    step("halt");
    chk("halt_h", W'(halted), 64'd1);
    chk("halt_valid", W'(pc_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      drive(3'($urandom_range(0, 7)), {$urandom, $urandom},
            {$urandom, $urandom}, 1'($urandom));
      fetch_ready = 1'($urandom); instr_valid = 1'($urandom);
      step("halt_hold");
      chk("halt_hold_pc", pc, 64'd7);
    end

    // reset mid-operation
    rst_n = 0; fetch_ready = 1; instr_valid = 1;
    step("rst2");
    chk("rst2_pc", pc, 64'd0);
    chk("rst2_halted", W'(halted), 64'd0);
    chk("rst2_cnt", W'(taken_count), 64'd0);
    rst_n = 1;
    step("boot2");

    // counter saturation
    drive(3'd1, 64'd1, '0, 0);
    for (int i = 0; i < 5; i++) begin
      step("sat");
      chk("sat_cnt", W'(taken_count), W'(i < 3 ? i + 1 : 3));
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      fetch_ready = ($urandom_range(0, 3) != 0);
      instr_valid = ($urandom_range(0, 3) != 0);
      branch_op = ($urandom_range(0, 19) == 0) ? 3'd5
                : 3'($urandom_range(0, 7));
      if (branch_op == 3'd5 && $urandom_range(0, 1) == 0)
        branch_op = 3'd0;
      se_offset = $urandom_range(0, 1) ? W'($signed($urandom_range(0, 40)) - 20)
                                       : {$urandom, $urandom};
      reg_target = {$urandom, $urandom};
      zero_flag = 1'($urandom);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
